// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save adder stages and the carry-propagate resolver.
package csa_pkg;

    localparam int CSA_WIDTH = 8;
    localparam int CSA_CHUNK = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int nchunks(input int rw, input int chunk);
        return (rw + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_resolve_seq_chk.sv
// Simulation checker: the resolver's final chunk can never produce a carry-out.
module csa_resolve_seq_chk (
    input logic clk,
    input logic rst_n,
    input logic last_chunk,
    input logic cout
);

    a_no_final_cout: assert property (@(posedge clk) disable iff (!rst_n) last_chunk |-> !cout);

endmodule

// File: rtl/csa_resolve_seq_cpa_chunk.sv
// cpa_chunk: CHUNK-bit ripple-carry adder built from full-adder cells.
module cpa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign cout = c_s[CHUNK];

endmodule

// File: rtl/csa_resolve_seq.sv
// Sequential carry-propagate resolver: out_result = in_sum + 2*in_carry, CHUNK bits per cycle.
// Optional macro CSA_RESOLVE_ZERO_SKIP_EN: an all-zero carry vector bypasses the ripple passes.
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_result,
    output logic             busy
);

    localparam int RW  = WIDTH + 2;
    localparam int NCH = nchunks(RW, CHUNK);
    localparam int PW  = NCH * CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    state_t          state_r;
    state_t          state_s;
    logic [PW-1:0]   a_r;
    logic [PW-1:0]   b_r;
    logic [RW-1:0]   result_r;
    logic [IW-1:0]   idx_r;
    logic            cy_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] sum_s;
    logic            cout_s;
    logic            accept_s;
    logic            zero_skip_s;
    logic            last_chunk_s;

    // Operands are padded to whole chunks, so the partial top chunk sees zeros.
    assign a_chunk_s    = a_r[32'(idx_r) * CHUNK +: CHUNK];
    assign b_chunk_s    = b_r[32'(idx_r) * CHUNK +: CHUNK];
    assign accept_s     = in_valid && in_ready_r;
    assign last_chunk_s = (state_r == ST_RUN) && (idx_r == LAST_IDX);

`ifdef CSA_RESOLVE_ZERO_SKIP_EN
    assign zero_skip_s = (in_carry == WIDTH'(0));
`else
    assign zero_skip_s = 1'b0;
`endif

    cpa_chunk #(
        .CHUNK (CHUNK)
    ) u_cpa (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (cy_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    csa_resolve_seq_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .last_chunk (last_chunk_s),
        .cout       (cout_s)
    );

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = zero_skip_s ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operand, chunk-result and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            idx_r       <= '0;
            cy_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
            if (accept_s) begin
                a_r   <= PW'(in_sum);
                b_r   <= PW'({in_carry, 1'b0});
                idx_r <= '0;
                cy_r  <= 1'b0;
                if (zero_skip_s) begin
                    result_r <= RW'(in_sum);
                end else begin
                    result_r <= result_r;
                end
            end else if (state_r == ST_RUN) begin
                idx_r <= idx_r + IW'(1);
                cy_r  <= cout_s;
                // Only bits below RW exist in the result; padding bits are dropped.
                for (int i = 0; i < RW; i++) begin
                    if ((i / CHUNK) == 32'(idx_r)) begin
                        result_r[i] <= sum_s[i % CHUNK];
                    end else begin
                        result_r[i] <= result_r[i];
                    end
                end
            end else begin
                idx_r <= idx_r;
                cy_r  <= cy_r;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = result_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench for csa_resolve_seq (WIDTH=8, CHUNK=4): vector table, corner sequences, random ops.
module tb_csa_resolve_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sum;
    logic [7:0] in_carry;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_result;
    logic       busy;

    int n_vec;
    int n_fail;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
        logic [9:0] res;
    } vec_t;

    vec_t tbl [0:6];

    csa_resolve_seq #(.WIDTH(8), .CHUNK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value of a carry-save pair and edges from accept to out_valid.
    function automatic int model_value(input int s, input int c);
        return s + 2 * c;
    endfunction

    function automatic int model_latency(input int c);
`ifdef CSA_RESOLVE_ZERO_SKIP_EN
        if (c == 0) return 0;
`endif
        return (8 + 2 + 4 - 1) / 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] s, input logic [7:0] c, input int exp_res, input int exp_lat);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        chk("ready_before_op", int'(in_ready), 1);
        in_sum    = s;
        in_carry  = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("busy_while_run", int'(busy), 1);
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", int'(out_result), exp_res);
        chk("busy_in_done", int'(busy), 1);
        step();
        chk("valid_drop", int'(out_valid), 0);
        chk("ready_after", int'(in_ready), 1);
    endtask

    initial begin
        int got [$];
        int idx;
        int guard;
        logic accepted;
        logic [7:0] rs;
        logic [7:0] rc;
        logic [7:0] pair_s [0:1];
        logic [7:0] pair_c [0:1];

        n_vec  = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sum = 8'h00;
        in_carry = 8'h00;
        out_ready = 1'b0;

        tbl[0] = '{s: 8'h0F, c: 8'h01, res: 10'h011};
        tbl[1] = '{s: 8'hFF, c: 8'hFF, res: 10'h2FD};
        tbl[2] = '{s: 8'h55, c: 8'h2A, res: 10'h0A9};
        tbl[3] = '{s: 8'h01, c: 8'h01, res: 10'h003};
        tbl[4] = '{s: 8'h10, c: 8'h08, res: 10'h020};
        tbl[5] = '{s: 8'h03, c: 8'h7F, res: 10'h101};
        tbl[6] = '{s: 8'hA5, c: 8'h00, res: 10'h0A5};

        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_result", int'(out_result), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].s, tbl[i].c, int'(tbl[i].res), model_latency(int'(tbl[i].c)));
        end

        // Backpressure: result and flags hold, a second request is ignored.
        in_sum = 8'h55;
        in_carry = 8'h2A;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("bp_reached_done", int'(out_valid), 1);
        in_sum = 8'h11;
        in_carry = 8'h11;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_result_hold", int'(out_result), model_value(8'h55, 8'h2A));
            chk("bp_valid_hold", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_no_second_accept", int'(busy), 0);
        chk("bp_result_kept", int'(out_result), model_value(8'h55, 8'h2A));

        // Reset one cycle after accepting an operation.
        in_sum = 8'h80;
        in_carry = 8'h80;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_result", int'(out_result), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();
        do_op(8'h01, 8'h01, model_value(1, 1), model_latency(1));

        // Back-to-back with in_valid held high.
        pair_s[0] = 8'h10; pair_c[0] = 8'h08;
        pair_s[1] = 8'h03; pair_c[1] = 8'h7F;
        idx = 0;
        in_sum = pair_s[0];
        in_carry = pair_c[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            accepted = in_valid && in_ready;
            if (out_valid) got.push_back(int'(out_result));
            step();
            if (accepted) begin
                idx++;
                if (idx < 2) begin
                    in_sum = pair_s[idx];
                    in_carry = pair_c[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("b2b_first", got[0], model_value(int'(pair_s[0]), int'(pair_c[0])));
            chk("b2b_second", got[1], model_value(int'(pair_s[1]), int'(pair_c[1])));
        end

        // Random operands against the arithmetic model.
        for (int r = 0; r < 40; r++) begin
            rs = 8'($urandom_range(0, 255));
            rc = (r % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            do_op(rs, rc, model_value(int'(rs), int'(rc)), model_latency(int'(rc)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
